// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte sources.
// A source may lock the line across several bytes so that its message is not
// interleaved with bytes from other sources. One byte is in flight at a time.
module uart_tx_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  input  logic              tx_busy,
  output logic [IDW-1:0]    owner,
  output logic              active
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic            locked_q, locked_d;
  logic [1:0]      wd_cnt_q, wd_cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            tx_wr_en_q, tx_wr_en_d;

  logic            pick_valid;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  cand;
  logic [7:0]      pick_byte;
  logic            pick_lock;

  // (base + off) modulo NREQ, for base < NREQ and off < NREQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return IDW'(sum);
  endfunction

  // Select the next source: the lock owner only, or the first requester at or after rr_ptr.
  // The ack cycle is skipped so the acked source's stale request is not picked again.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    if (ack_q == '0 && !tx_busy) begin
      if (locked_q) begin
        pick_valid = req[owner_q];
        pick_idx   = owner_q;
      end else begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          cand = wrap_idx(rr_ptr_q, k);
          if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
          end
        end
      end
    end
  end

  // Mux the picked source's byte and lock flag.
  always_comb begin
    pick_byte = 8'h00;
    pick_lock = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_idx == IDW'(k)) begin
        pick_byte = req_data[k*8 +: 8];
        pick_lock = req_lock[k];
      end
    end
  end

  // Next-state logic for the issue/handshake FSM and the arbitration state.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    locked_d   = locked_q;
    wd_cnt_d   = wd_cnt_q;
    ack_d      = '0;
    tx_wr_en_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          tx_data_d = pick_byte;
          owner_d   = pick_idx;
          lock_d    = pick_lock;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        // Strobe is registered, so the transmitter sees it on the following cycle.
        tx_wr_en_d = 1'b1;
        wd_cnt_d   = 2'd0;
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (wd_cnt_q == 2'd3) begin
          // Transmitter never took the byte: drop back and retry, request stays pending.
          state_d = StIdle;
        end else begin
          wd_cnt_d = wd_cnt_q + 2'd1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          ack_d[owner_q] = 1'b1;
          locked_d       = lock_q;
          if (!lock_q) begin
            rr_ptr_d = wrap_idx(owner_q, 1);
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_data_q  <= 8'h00;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      locked_q   <= 1'b0;
      wd_cnt_q   <= 2'd0;
      ack_q      <= '0;
      tx_wr_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      locked_q   <= locked_d;
      wd_cnt_q   <= wd_cnt_d;
      ack_q      <= ack_d;
      tx_wr_en_q <= tx_wr_en_d;
    end
  end

  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_wr_en = tx_wr_en_q;
  assign owner    = owner_q;
  assign active   = (state_q != StIdle) | locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: reset-based vector table, hand-written
// corner sequences and a randomized run checked against a source-level reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req, req_lock, ack;
  logic [31:0]     req_data;
  logic [7:0]      tx_data;
  logic            tx_wr_en, tx_busy;
  logic [1:0]      owner;
  logic            active;

  uart_tx_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_lock (req_lock),
    .req_data (req_data),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_wr_en (tx_wr_en),
    .tx_busy  (tx_busy),
    .owner    (owner),
    .active   (active)
  );

  always #5 clk = ~clk;

  // Source model: per-source queue of {lock, byte}; head is presented while non-empty.
  logic [8:0] srcq [NREQ][$];
  int log_s[$], log_b[$];
  int exp_s[$], exp_b[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, wr_cnt = 0, acks = 0, added = 0;
  int last_wr_cyc, last_wr_data, last_ack, ack_cyc, busy_fall_cyc;
  bit ack_now;
  // Transmitter model
  bit tx_auto, busy_rand;
  int busy_len, busy_cnt;
  // Reference arbitration state
  int m_rr, m_owner, m_cur;
  bit m_locked, m_cur_lock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void drive_src();
    for (int i = 0; i < NREQ; i++) begin
      req[i]          = srcq[i].size() > 0;
      req_lock[i]     = (srcq[i].size() > 0) ? srcq[i][0][8] : 1'b0;
      req_data[8*i +: 8] = (srcq[i].size() > 0) ? srcq[i][0][7:0] : 8'h00;
    end
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += srcq[i].size();
    return n;
  endfunction

  function automatic void model_reset();
    m_rr = 0; m_owner = 0; m_cur = -1; m_locked = 0; m_cur_lock = 0;
  endfunction

  // A byte was strobed: it must come from the source the round-robin/lock rules select.
  task automatic model_issue();
    int e;
    e = -1;
    if (m_locked) e = m_owner;
    else
      for (int k = 0; k < NREQ; k++)
        if (e < 0 && req[(m_rr + k) % NREQ]) e = (m_rr + k) % NREQ;
    if (e < 0 || srcq[e].size() == 0) begin
      chk("grant_spurious", 1, 0);
      m_cur = -1;
    end else begin
      chk("grant_owner", owner, e);
      chk("grant_byte", tx_data, srcq[e][0][7:0]);
      chk("grant_tx_idle", tx_busy, 0);
      m_cur = e;
      m_cur_lock = srcq[e][0][8];
    end
  endtask

  task automatic model_ack();
    int s;
    s = -1;
    for (int k = 0; k < NREQ; k++) if (s < 0 && ack[k]) s = k;
    chk("ack_vec", ack, (m_cur >= 0) ? (1 << m_cur) : 0);
    if (s >= 0 && srcq[s].size() > 0) begin
      log_s.push_back(s);
      log_b.push_back(srcq[s][0][7:0]);
      void'(srcq[s].pop_front());
    end
    if (m_cur >= 0) begin
      m_locked = m_cur_lock;
      m_owner  = m_cur;
      if (!m_cur_lock) m_rr = (m_cur + 1) % NREQ;
    end
    m_cur = -1;
    acks++;
  endtask

  // One cycle: sample at the falling edge, update models, then drive new inputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    ack_now = 1'b0;
    chk("ack_wr_exclusive", int'((tx_wr_en && ack != 0) || $countones(ack) > 1), 0);
    if (tx_wr_en) begin
      wr_cnt++;
      last_wr_cyc  = cyc;
      last_wr_data = tx_data;
      model_issue();
    end
    if (ack != 0) begin
      ack_now  = 1'b1;
      ack_cyc  = cyc;
      last_ack = ack;
      model_ack();
    end
    if (tx_busy && busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        tx_busy = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
    if (tx_wr_en && tx_auto) begin
      tx_busy  = 1'b1;
      busy_cnt = busy_rand ? int'($urandom_range(1, 6)) : busy_len;
    end
    drive_src();
  endtask

  task automatic wait_wr(input string name);
    int tgt;
    tgt = wr_cnt + 1;
    for (int n = 0; n < 100 && wr_cnt < tgt; n++) tick();
    chk(name, int'(wr_cnt >= tgt), 1);
  endtask

  task automatic run_until_idle(input string name);
    int n;
    n = 0;
    while ((pending() > 0 || m_cur >= 0 || tx_busy) && n < 3000) begin
      tick();
      n++;
    end
    chk(name, int'(n < 3000), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tx_busy = 1'b0; busy_cnt = 0; tx_auto = 1'b1; busy_rand = 1'b0; busy_len = 3;
    for (int i = 0; i < NREQ; i++) srcq[i].delete();
    drive_src();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, log_s.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < log_s.size(); i++) begin
      chk({name, "_src"}, log_s[i], exp_s[i]);
      chk({name, "_byte"}, log_b[i], exp_b[i]);
    end
  endtask

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] data;
    int          src;
    logic [7:0]  b;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int t0, wr_at, own_at, dat_at, a0, w0, w;
    bit seen;

    // From reset rr_ptr=0, so the lowest-numbered requester wins.
    vecs[0] = '{rq: 4'b0001, data: 32'h1122_3348, src: 0, b: 8'h48};
    vecs[1] = '{rq: 4'b0110, data: 32'hA1B2_C3D4, src: 1, b: 8'hC3};
    vecs[2] = '{rq: 4'b1000, data: 32'h7E00_0000, src: 3, b: 8'h7E};
    vecs[3] = '{rq: 4'b1100, data: 32'h5A3C_0000, src: 2, b: 8'h3C};
    vecs[4] = '{rq: 4'b1111, data: 32'hDEAD_BEEF, src: 0, b: 8'hEF};
    vecs[5] = '{rq: 4'b1010, data: 32'h00FF_8000, src: 1, b: 8'h80};

    rst = 1'b1; req = '0; req_lock = '0; req_data = '0; tx_busy = 1'b0;
    model_reset();
    do_reset();
    chk("rst_ack", ack, 0);
    chk("rst_wr_en", tx_wr_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_active", active, 0);

    // Vector table: single grant from reset, latency, byte, ack timing.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < NREQ; i++)
        if (vecs[v].rq[i]) srcq[i].push_back({1'b0, vecs[v].data[8*i +: 8]});
      drive_src();
      t0 = cyc; seen = 0; a0 = acks; wr_at = -100; own_at = -1; dat_at = -1;
      for (int n = 0; n < 40 && acks == a0; n++) begin
        tick();
        if (tx_wr_en && !seen) begin
          seen = 1; wr_at = cyc; own_at = owner; dat_at = tx_data;
        end
      end
      chk("vec_acked", acks - a0, 1);
      chk("vec_latency", wr_at - t0, 2);
      chk("vec_owner", own_at, vecs[v].src);
      chk("vec_byte", dat_at, vecs[v].b);
      chk("vec_ack_after_busy", ack_cyc - busy_fall_cyc, 1);
      chk("vec_ack_bit", last_ack, 1 << vecs[v].src);
    end

    // All four requesting, unlocked: strict rotation 0,1,2,3,0.
    do_reset();
    log_s.delete(); log_b.delete();
    srcq[0].push_back({1'b0, 8'h10}); srcq[0].push_back({1'b0, 8'h14});
    srcq[1].push_back({1'b0, 8'h11});
    srcq[2].push_back({1'b0, 8'h12});
    srcq[3].push_back({1'b0, 8'h13});
    drive_src();
    run_until_idle("rot_done");
    exp_s = '{0, 1, 2, 3, 0}; exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_log("rot");

    // Locked message "Hi!" from src1 while src0 and src2 request.
    do_reset();
    log_s.delete(); log_b.delete();
    srcq[1].push_back({1'b1, 8'h48}); srcq[1].push_back({1'b1, 8'h69});
    srcq[1].push_back({1'b0, 8'h21});
    drive_src();
    wait_wr("lock_first_wr");
    srcq[0].push_back({1'b0, 8'h30});
    srcq[2].push_back({1'b0, 8'h32});
    drive_src();
    run_until_idle("lock_done");
    exp_s = '{1, 1, 1, 2, 0}; exp_b = '{8'h48, 8'h69, 8'h21, 8'h32, 8'h30};
    check_log("lock");

    // Reset while waiting for the transmitter to finish a byte.
    do_reset();
    log_s.delete(); log_b.delete();
    busy_len = 12;
    srcq[0].push_back({1'b0, 8'hC7});
    drive_src();
    wait_wr("rstmid_wr");
    tick(); tick(); tick();
    chk("rstmid_busy_high", tx_busy, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_ack", ack, 0);
    chk("rstmid_wr_en", tx_wr_en, 0);
    chk("rstmid_tx_data", tx_data, 0);
    chk("rstmid_owner", owner, 0);
    chk("rstmid_active", active, 0);
    model_reset();
    tick();
    rst = 1'b0;
    w0 = wr_cnt;
    for (int n = 0; n < 30 && tx_busy; n++) tick();
    chk("rstmid_no_wr_while_busy", wr_cnt - w0, 0);
    busy_len = 3;
    wait_wr("rstmid_reissue");
    chk("rstmid_reissue_byte", last_wr_data, 8'hC7);
    run_until_idle("rstmid_done");
    exp_s = '{0}; exp_b = '{8'hC7};
    check_log("rstmid");

    // Transmitter ignores the strobe: watchdog gives up after 4 cycles, then retries.
    do_reset();
    log_s.delete(); log_b.delete();
    tx_auto = 1'b0;
    srcq[1].push_back({1'b0, 8'h3E});
    drive_src();
    a0 = acks;
    wait_wr("wd_first_wr");
    w = last_wr_cyc;
    for (int n = 0; n < 10 && active; n++) tick();
    chk("wd_return_cycles", cyc - w, 4);
    chk("wd_no_ack", acks - a0, 0);
    tx_auto = 1'b1;
    wait_wr("wd_retry_wr");
    chk("wd_retry_byte", last_wr_data, 8'h3E);
    run_until_idle("wd_done");
    chk("wd_single_ack", acks - a0, 1);

    // rr_ptr wrap: src2 then src3 move the pointer to 0; then {3,0} grants src0 first.
    do_reset();
    log_s.delete(); log_b.delete();
    srcq[2].push_back({1'b0, 8'h20}); drive_src(); run_until_idle("wrap_a");
    srcq[3].push_back({1'b0, 8'h33}); drive_src(); run_until_idle("wrap_b");
    srcq[0].push_back({1'b0, 8'h40}); srcq[3].push_back({1'b0, 8'h43});
    drive_src(); run_until_idle("wrap_c");
    exp_s = '{2, 3, 0, 3}; exp_b = '{8'h20, 8'h33, 8'h40, 8'h43};
    check_log("wrap");

    // Locked owner goes quiet: nobody else is served until it releases the lock.
    do_reset();
    log_s.delete(); log_b.delete();
    srcq[1].push_back({1'b1, 8'h55}); drive_src(); run_until_idle("drop_a");
    srcq[0].push_back({1'b0, 8'hAA}); drive_src();
    w0 = wr_cnt;
    for (int n = 0; n < 20; n++) tick();
    chk("drop_no_grant", wr_cnt - w0, 0);
    chk("drop_active", active, 1);
    srcq[1].push_back({1'b0, 8'h66}); drive_src(); run_until_idle("drop_b");
    exp_s = '{1, 1, 0}; exp_b = '{8'h55, 8'h66, 8'hAA};
    check_log("drop");

    // Randomized traffic: messages of 1-3 bytes, random transmitter busy time.
    do_reset();
    busy_rand = 1'b1;
    a0 = acks; added = 0;
    for (int it = 0; it < 6000 && added < 250; it++) begin
      tick();
      if (ack_now || (pending() == 0 && m_cur < 0)) begin
        for (int i = 0; i < NREQ; i++) begin
          if (srcq[i].size() == 0 && $urandom_range(0, 1) == 1) begin
            int len;
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++)
              srcq[i].push_back({(j < len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
            added += len;
          end
        end
        drive_src();
      end
    end
    run_until_idle("rand_drain");
    chk("rand_all_acked", acks - a0, added);
    chk("rand_released", active, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
